// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline stall/flush
//            controller (controller states, boundary bit indices,
//            timeout counter sizing).
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Bit positions inside stall_o / flush_o
    localparam int IF_ID  = 0;
    localparam int ID_EX  = 1;
    localparam int EX_MEM = 2;
    localparam int MEM_WB = 3;

    // Timeout counter width: $clog2(MEM_TIMEOUT), never narrower than 1 bit
    function automatic int tmo_cnt_w(input int timeout);
        int w;
        w = $clog2(timeout);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_load_use.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Purpose  : Flags a load in EX whose destination is read by the ID
//            instruction. x0 never creates a hazard.
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect #(
    parameter int RAW = 5
) (
    input  logic           i_ex_is_load,
    input  logic [RAW-1:0] i_ex_rd,
    input  logic           i_rs1_en,
    input  logic [RAW-1:0] i_rs1,
    input  logic           i_rs2_en,
    input  logic [RAW-1:0] i_rs2,
    output logic           o_load_use
);

    logic w_rd_nonzero;
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rd_nonzero = |i_ex_rd;
    assign w_rs1_hit    = i_rs1_en & (i_rs1 == i_ex_rd);
    assign w_rs2_hit    = i_rs2_en & (i_rs2 == i_ex_rd);
    assign o_load_use   = i_ex_is_load & w_rd_nonzero & (w_rs1_hit | w_rs2_hit);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Central stall/flush controller for the 5-stage pipeline.
//            Priority: bus wait > MDU wait > jump > load-use.
//            All control outputs are combinational (same-cycle).
//            Optional macro PIPE_CTRL_PERF_EN adds 64-bit stall/flush
//            performance counters; otherwise those ports read 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int RAW         = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_rs1_en_i,
    input  logic              id_rs2_en_i,
    input  logic [RAW-1:0]    id_rs1_i,
    input  logic [RAW-1:0]    id_rs2_i,
    input  logic              ex_is_load_i,
    input  logic [RAW-1:0]    ex_rd_i,
    input  logic              ex_mdu_op_i,
    input  logic              mdu_done_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic              pc_stall_o,
    output logic [3:0]        stall_o,
    output logic [3:0]        flush_o,
    output logic              jump_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              bus_err_o,
    output logic [63:0]       stall_cnt_o,
    output logic [63:0]       flush_cnt_o
);

    localparam int               TMO_W    = tmo_cnt_w(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic w_in_run;
    logic w_in_mem;
    logic w_timeout;
    logic w_memwait;
    logic w_mduwait;
    logic w_loaduse;

    load_use_detect #(
        .RAW (RAW)
    ) u_load_use (
        .i_ex_is_load (ex_is_load_i),
        .i_ex_rd      (ex_rd_i),
        .i_rs1_en     (id_rs1_en_i),
        .i_rs1        (id_rs1_i),
        .i_rs2_en     (id_rs2_en_i),
        .i_rs2        (id_rs2_i),
        .o_load_use   (w_loaduse)
    );

    assign w_in_run  = (r_state == RUN);
    assign w_in_mem  = (r_state == MEM_WAIT);
    // Ready in the last allowed cycle beats the timeout.
    assign w_timeout = w_in_mem & (r_tmo_cnt == TMO_LAST) & ~mem_ready_i;
    assign w_memwait = (w_in_run & mem_req_i & ~mem_ready_i)
                     | (w_in_mem & ~mem_ready_i & ~w_timeout);
    // Outside a bus wait every state (including a release cycle) looks like
    // RUN, so the MDU check does not depend on the state.
    assign w_mduwait = ex_mdu_op_i & ~mdu_done_i;

    // Prioritised stall/flush/redirect decode; reset forces every boundary to bubble.
    always_comb begin
        pc_stall_o  = 1'b0;
        stall_o     = 4'b0000;
        flush_o     = 4'b0000;
        jump_o      = 1'b0;
        jump_addr_o = '0;
        bus_err_o   = 1'b0;
        if (!rst) begin
            flush_o = 4'b1111;
        end else begin
            bus_err_o = w_timeout;
            if (w_memwait) begin
                pc_stall_o      = 1'b1;
                stall_o[IF_ID]  = 1'b1;
                stall_o[ID_EX]  = 1'b1;
                stall_o[EX_MEM] = 1'b1;
                flush_o[MEM_WB] = 1'b1;
            end else if (w_mduwait) begin
                pc_stall_o      = 1'b1;
                stall_o[IF_ID]  = 1'b1;
                stall_o[ID_EX]  = 1'b1;
                flush_o[EX_MEM] = 1'b1;
            end else if (jump_en_i) begin
                jump_o          = 1'b1;
                jump_addr_o     = jump_addr_i;
                flush_o[IF_ID]  = 1'b1;
                flush_o[ID_EX]  = 1'b1;
            end else if (w_loaduse) begin
                pc_stall_o      = 1'b1;
                stall_o[IF_ID]  = 1'b1;
                flush_o[ID_EX]  = 1'b1;
            end
        end
    end

    // Next state follows the same priority as the output decode.
    always_comb begin
        w_next_state = RUN;
        if (w_memwait) begin
            w_next_state = MEM_WAIT;
        end else if (w_mduwait) begin
            w_next_state = MDU_WAIT;
        end
    end

    // State register and bus-wait cycle counter (zero on the first MEM_WAIT cycle).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= RUN;
            r_tmo_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_in_mem) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] r_stall_cnt;
    logic [63:0] r_flush_cnt;

    // Free-running performance counters, wrapping at 2^64.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= 64'd0;
            r_flush_cnt <= 64'd0;
        end else begin
            if (pc_stall_o) begin
                r_stall_cnt <= r_stall_cnt + 64'd1;
            end
            if (jump_o) begin
                r_flush_cnt <= r_flush_cnt + 64'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = 64'd0;
    assign flush_cnt_o = 64'd0;
`endif

endmodule : pipe_ctrl
`default_nettype wire
